// File: rtl/heatmap_vga_pkg.sv
// Shared defaults and FSM state type for the heat-map VGA pixel path.
package heatmap_vga_pkg;

    localparam int unsigned DEF_ADDR_W     = 19;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_CLK_PER_MS = 50000;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StArb,
        StHold,
        StDone
    } sched_state_e;

endpackage

// File: rtl/rr_grant_picker.sv
// Round-robin picker: searches upward from last_grant+1 (mod N_REQ) and
// owns the last_grant pointer, which moves only on an advance strobe.
module rr_grant_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             advance,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_valid
);

    logic [IDX_W-1:0] last_grant_q;

    // First valid requester after the pointer, wrapping at N_REQ.
    always_comb begin
        logic found;
        int   idx;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = (int'(last_grant_q) + k) % int'(N_REQ);
            if (!found && req_valid[IDX_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        any_valid = |req_valid;
    end

    // Pointer resets to N_REQ-1 so requester 0 wins the first search.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= IDX_W'(N_REQ - 1);
        end else if (advance) begin
            last_grant_q <= grant_idx;
        end
    end

endmodule

// File: rtl/heatmap_pixel_scheduler.sv
// Frame sequencer and round-robin arbiter for the shared VGA SRAM write port.
// Optional frame timer: define HEATMAP_FRAME_TIMER_EN.
module heatmap_pixel_scheduler
    import heatmap_vga_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CLK_PER_MS = DEF_CLK_PER_MS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_key_n,
    input  logic                    hps_start,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_color,
    input  logic [N_REQ-1:0]        req_done,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    solver_start,
    output logic [ADDR_W-1:0]       sram_address,
    output logic                    sram_write,
    output logic [DATA_W-1:0]       sram_writedata,
    output logic                    frame_done,
    output logic [31:0]             frame_ms
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_e     state_q, state_d;
    logic             start;
    logic             advance;
    logic             any_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_onehot;

    assign start = ~start_key_n | hps_start;

    rr_grant_picker #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_picker (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .advance  (advance),
        .grant_idx(grant_idx),
        .any_valid(any_valid)
    );

    // Next state; valid beats done in ARB, HOLD ignores requests.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        unique case (state_q)
            StIdle:  if (start) state_d = StStart;
            StStart: state_d = StArb;
            StArb: begin
                if (any_valid) begin
                    advance = 1'b1;
                    state_d = StHold;
                end else if (&req_done) begin
                    state_d = StDone;
                end
            end
            StHold:  state_d = StArb;
            StDone:  if (start) state_d = StStart;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // One-hot form of the grant index for the acknowledge.
    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_idx] = 1'b1;
    end

    // Registered outputs: write strobe and ack appear the cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            solver_start   <= 1'b0;
            sram_write     <= 1'b0;
            req_ack        <= '0;
            sram_address   <= '0;
            sram_writedata <= '0;
        end else begin
            solver_start <= (state_q == StStart);
            sram_write   <= advance;
            req_ack      <= advance ? grant_onehot : '0;
            if (advance) begin
                sram_address   <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                sram_writedata <= req_color[grant_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign frame_done = (state_q == StDone);

`ifdef HEATMAP_FRAME_TIMER_EN
    logic [31:0] presc_q, presc_d;
    logic [31:0] ms_q, ms_d;
    logic [31:0] frame_ms_q;

    // Prescaled ms counter, running only while the frame is being drawn.
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if (state_q == StStart) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (state_q == StArb || state_q == StHold) begin
            if (presc_q == 32'(CLK_PER_MS - 1)) begin
                presc_d = '0;
                ms_d    = ms_q + 32'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    // Counter state and capture of the duration on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            ms_q       <= '0;
            frame_ms_q <= '0;
        end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
            if (state_q == StStart) begin
                frame_ms_q <= '0;
            end else if (state_q == StArb && state_d == StDone) begin
                frame_ms_q <= ms_d;
            end
        end
    end

    assign frame_ms = frame_ms_q;
`else
    // Keeps the timer parameter referenced when the timer is compiled out.
    logic unused_clk_per_ms;
    assign unused_clk_per_ms = ^(32'(CLK_PER_MS));
    assign frame_ms = '0;
`endif

endmodule

// File: tb/tb_heatmap_pixel_scheduler.sv
// Randomized bench for heatmap_pixel_scheduler with a transaction-level
// round-robin model and per-cycle output expectations.
module tb_heatmap_pixel_scheduler;

    localparam int N  = 4;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int MS = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_key_n;
    logic            hps_start;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_color;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_ack;
    logic            solver_start;
    logic [AW-1:0]   sram_address;
    logic            sram_write;
    logic [DW-1:0]   sram_writedata;
    logic            frame_done;
    logic [31:0]     frame_ms;

    heatmap_pixel_scheduler #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLK_PER_MS(MS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_key_n   (start_key_n),
        .hps_start     (hps_start),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_color     (req_color),
        .req_done      (req_done),
        .req_ack       (req_ack),
        .solver_start  (solver_start),
        .sram_address  (sram_address),
        .sram_write    (sram_write),
        .sram_writedata(sram_writedata),
        .frame_done    (frame_done),
        .frame_ms      (frame_ms)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          cyc = 0;
    int          start_cyc = -100;
    int          last_write_cyc = -100;
    int          fd_cyc = -100;
    int          model_last = N - 1;
    int          first_grant = -1;
    int          writes_in_frame = 0;
    int          gap_max = 0;
    bit          in_frame = 1'b0;
    bit          fd_hold = 1'b0;
    bit          fix_pix = 1'b0;
    int          rem[N];
    int          gap[N];
    bit          early[N];
    logic [N-1:0] vld;
    logic [AW-1:0] pa[N];
    logic [DW-1:0] pc[N];
    logic [N-1:0] prev_valid = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_rem_zero();
        for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = vld[i];
            req_addr[i*AW +: AW]    = pa[i];
            req_color[i*DW +: DW]   = pc[i];
            req_done[i]             = (rem[i] == 0) || (early[i] && vld[i] && rem[i] == 1);
        end
        prev_valid = req_valid;
    endtask

    // One cycle: observe at negedge against the model, then drive requesters.
    task automatic tick();
        int  acked;
        bit  exp_write;
        int  g;
        logic [31:0] exp_ms;
        @(negedge clk);
        cyc++;
        acked = -1;
        check_eq("solver_start", {31'd0, solver_start}, {31'd0, cyc == start_cyc + 2});
        if (cyc == start_cyc + 2) in_frame = 1'b1;
        exp_write = in_frame && (prev_valid != '0) && (cyc - 1 != last_write_cyc);
        check_eq("sram_write", {31'd0, sram_write}, {31'd0, exp_write});
        if (exp_write) begin
            g = rr_pick(prev_valid, model_last);
            check_eq("req_ack", {28'd0, req_ack}, 32'(1 << g));
            check_eq("sram_address", {13'd0, sram_address}, {13'd0, pa[g]});
            check_eq("sram_writedata", {24'd0, sram_writedata}, {24'd0, pc[g]});
            model_last     = g;
            last_write_cyc = cyc;
            acked          = g;
            if (writes_in_frame == 0) first_grant = g;
            writes_in_frame++;
        end else begin
            check_eq("req_ack_idle", {28'd0, req_ack}, 32'd0);
        end
        if (cyc == start_cyc + 1) fd_hold = 1'b0;
        if (in_frame && all_rem_zero() && cyc == last_write_cyc + 2) begin
            fd_hold  = 1'b1;
            in_frame = 1'b0;
            fd_cyc   = cyc;
        end
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, fd_hold});
        if (cyc == fd_cyc) begin
`ifdef HEATMAP_FRAME_TIMER_EN
            exp_ms = 32'((fd_cyc - start_cyc - 2) / MS);
`else
            exp_ms = 32'd0;
`endif
            check_eq("frame_ms", frame_ms, exp_ms);
        end
        if (in_frame) begin
            for (int i = 0; i < N; i++) begin
                if (acked == i) begin
                    rem[i]--;
                    vld[i] = 1'b0;
                    gap[i] = $urandom_range(0, gap_max);
                end
                if (!vld[i] && rem[i] > 0) begin
                    if (gap[i] == 0) begin
                        vld[i] = 1'b1;
                        pa[i]  = fix_pix ? AW'(19'h00123) : AW'($urandom);
                        pc[i]  = fix_pix ? DW'(8'hE0) : DW'($urandom);
                    end else begin
                        gap[i]--;
                    end
                end
            end
            drive_reqs();
        end
    endtask

    // Caller sets rem[], early[], gap_max beforehand.
    task automatic launch_frame(input bit use_key);
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            gap[i] = $urandom_range(0, gap_max);
        end
        req_valid       = '0;
        req_done        = '0;
        prev_valid      = '0;
        writes_in_frame = 0;
        first_grant     = -1;
        last_write_cyc  = -100;
        if (use_key) start_key_n = 1'b0;
        else         hps_start   = 1'b1;
        start_cyc = cyc;
        tick();
        start_key_n = 1'b1;
        hps_start   = 1'b0;
    endtask

    task automatic finish_frame();
        int budget;
        budget = 0;
        while (!(fd_hold && cyc > start_cyc + 1) && budget < 3000) begin
            tick();
            budget++;
        end
        if (budget >= 3000) check_eq("frame_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start_key_n = 1'b1;
        hps_start   = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_color   = '0;
        req_done    = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; gap[i] = 0; early[i] = 1'b0; pa[i] = '0; pc[i] = '0;
        end
        vld = '0;
        tick();
        tick();
        check_eq("reset_address", {13'd0, sram_address}, 32'd0);
        check_eq("reset_wdata", {24'd0, sram_writedata}, 32'd0);
        check_eq("reset_frame_ms", frame_ms, 32'd0);
        reset = 1'b0;
        tick();

        // Single request on requester 2 with fixed pixel.
        fix_pix = 1'b1;
        gap_max = 0;
        rem[0] = 0; rem[1] = 0; rem[2] = 1; rem[3] = 0;
        launch_frame(1'b1);
        finish_frame();
        check_eq("single_first_grant", 32'(first_grant), 32'd2);
        fix_pix = 1'b0;

        // Fairness: everyone always valid.
        for (int i = 0; i < N; i++) begin rem[i] = 6; early[i] = 1'b0; end
        launch_frame(1'b0);
        finish_frame();
        check_eq("fair_writes", 32'(writes_in_frame), 32'd24);

        // Done raised together with a final valid pixel.
        rem[0] = 1; rem[1] = 0; rem[2] = 0; rem[3] = 0;
        early[0] = 1'b1;
        launch_frame(1'b1);
        finish_frame();
        check_eq("done_with_valid_writes", 32'(writes_in_frame), 32'd1);
        early[0] = 1'b0;

        // Randomized frames with gaps, early done and restarts from DONE.
        gap_max = 3;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                rem[i]   = $urandom_range(0, 5);
                early[i] = 1'($urandom_range(0, 1));
            end
            if (rem[0] == 0) rem[0] = 1;
            launch_frame(1'(f & 1));
            finish_frame();
        end

        // Reset while a write is being held.
        gap_max = 0;
        for (int i = 0; i < N; i++) begin rem[i] = 3; early[i] = 1'b0; end
        launch_frame(1'b0);
        begin
            int budget;
            budget = 0;
            while (writes_in_frame < 2 && budget < 100) begin
                tick();
                budget++;
            end
            if (budget >= 100) check_eq("hold_timeout", 32'd0, 32'd1);
        end
        reset      = 1'b1;
        in_frame   = 1'b0;
        fd_hold    = 1'b0;
        model_last = N - 1;
        start_cyc  = -100;
        last_write_cyc = -100;
        for (int i = 0; i < N; i++) begin rem[i] = 0; vld[i] = 1'b0; end
        req_valid  = '0;
        req_done   = '0;
        prev_valid = '0;
        tick();
        reset = 1'b0;
        tick();
        rem[0] = 1; rem[1] = 0; rem[2] = 0; rem[3] = 1;
        launch_frame(1'b1);
        finish_frame();
        check_eq("after_reset_first_grant", 32'(first_grant), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
